// File: rtl/shift_left_seq.sv
// Multi-cycle left-shift sequencer: loads a word, then shifts one bit per clock for shamt cycles.
// Define ROTATE_EN to refill the LSB with the outgoing MSB (rotate) instead of the captured sin.
module shift_left_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] shamt,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               shift_in;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ROTATE_EN
    // sin has no role when rotating; the LSB takes the outgoing MSB.
    logic unused_sin;
    assign unused_sin = sin;
    assign shift_in   = data_q[WIDTH-1];
`else
    logic fill_q, fill_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (state_q == StIdle && start) begin
            fill_d = sin;
        end
    end

    assign shift_in = fill_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = load_data;
                    cnt_d   = shamt;
                    cout_d  = 1'b0;
                    state_d = (shamt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                data_d = {data_q[WIDTH-2:0], shift_in};
                cout_d = data_q[WIDTH-1];
                cnt_d  = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_out = data_q;
    assign cout     = cout_q;
    assign busy     = (state_q == StShift);
    assign done     = (state_q == StDone);

endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Multi-cycle left-shift sequencer that sits directly downstream of the 4-bit combinational left-shift slice. It registers a WIDTH-bit word and applies one single-bit left shift per clock for a requested count, with a fill bit and carry-out captured like the slice's cin/cout. A start/busy/done handshake lets a controller request a shift and collect the result.

## Interface

- WIDTH, 16, data word width; must be a multiple of 4 and at least 4.
- CNT_W, 4, shift-count width; the maximum count is 2^CNT_W-1.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- load_data  input  WIDTH  word to shift; captured on an accepted start.
- shamt  input  CNT_W  number of single-bit shifts; captured on an accepted start.
- sin  input  1  fill bit shifted into the LSB; captured on an accepted start.
- data_out  output  WIDTH  current register contents.
- cout  output  1  bit shifted out of the MSB by the most recent shift.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle completion pulse.

## Operation

- Reset values: data_out=0, cout=0, busy=0, done=0, state=IDLE. Reset overrides every other input.
- States:
  - IDLE: an accepted start (start=1) performs the following on that edge:
    - data_reg<=load_data, cnt<=shamt, fill<=sin, cout<=0.
    - Next state is SHIFT if shamt!=0; otherwise DONE.
  - SHIFT: on each edge:
    - data_reg<={data_reg[WIDTH-2:0], fill}, cout<=data_reg[WIDTH-1], cnt<=cnt-1.
    - When cnt==1 at the edge, next state is DONE.
  - DONE: done=1 for exactly this cycle; the next edge goes to IDLE.
- start is ignored in SHIFT and DONE. No queueing; a later start must be issued while busy=0 and done=0.
- data_out and cout hold their values in IDLE until the next accepted start.
- Inputs load_data, shamt and sin may change freely after the accepting edge.
- A reset mid-SHIFT aborts the operation: no done pulse, all outputs return to reset values.

## Timing

- Edge 0 accepts start.
  - With shamt=N≥1: busy=1 for cycles 1..N, done=1 in cycle N+1, data_out is final from cycle N+1.
  - With shamt=0: done=1 in cycle 1, data_out=load_data, cout=0.
- Throughput is one operation per N+2 cycles when start is re-issued on the first IDLE cycle.
- busy and done are registered (state-decoded) and never both high.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration

- ROTATE_EN:
  - Defined: rotate mode. Each SHIFT edge fills the LSB with data_reg[WIDTH-1] and sin is ignored. cout still captures the rotated-out MSB.
  - Undefined: logical shift with the captured sin fill, as described in Operation.

## Test plan

- Reset: hold rst for 2 cycles with start=1 -> data_out=0, cout=0, busy=0, done=0 throughout reset and on the first cycle after release.
- load_data=16'h0003, shamt=2, sin=0 -> busy for 2 cycles, done 3 cycles after the start edge, data_out=16'h000C, cout=0.
- load_data=16'hFFFF, shamt=4:
  - sin=1 -> data_out=16'hFFFF, cout=1.
  - sin=0 -> data_out=16'hFFF0, cout=1.
- load_data=16'h1234, shamt=0 -> done in cycle 1, busy never asserted, data_out=16'h1234, cout=0.
- Issue a second start with load_data=16'hAAAA mid-SHIFT -> ignored and the first result is unchanged. Then assert rst in cycle 2 of a shamt=5 run -> no done, outputs=0.
- ROTATE_EN defined, load_data=16'h8001, shamt=1, sin=0 -> data_out=16'h0003, cout=1. With shamt=15 -> data_out=16'hC000.
